// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one combinational ALU.
// Operands are registered before execution, and each port has a one-entry response buffer.
module alu_share_arbiter #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [Width-1:0] req0_a,
    input  logic [Width-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [Width-1:0] req1_a,
    input  logic [Width-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [Width-1:0] rsp0_result,
    output logic [3:0]       rsp0_flags,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [Width-1:0] rsp1_result,
    output logic [3:0]       rsp1_flags,
    output logic [Width-1:0] alu_a,
    output logic [Width-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [Width-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   elig0;
    logic   elig1;
    logic   grant0;
    logic   grant1;

    // A port with a full response buffer cannot be granted, even if it drains this cycle.
    always_comb begin
        elig0      = req0_valid & ~rsp0_valid;
        elig1      = req1_valid & ~rsp1_valid;
        grant0     = elig0 & (~elig1 | last_grant);
        grant1     = elig1 & (~elig0 | ~last_grant);
        req0_ready = (state == IDLE) & grant0;
        req1_ready = (state == IDLE) & grant1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= 3'b000;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_flags  <= 4'b0000;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_flags  <= 4'b0000;
        end else begin
            if (rsp0_valid && rsp0_ready) rsp0_valid <= 1'b0;
            if (rsp1_valid && rsp1_ready) rsp1_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_a      <= grant1 ? req1_a    : req0_a;
                        alu_b      <= grant1 ? req1_b    : req0_b;
                        alu_ctrl   <= grant1 ? req1_ctrl : req0_ctrl;
                        owner      <= grant1;
                        last_grant <= grant1;
                        state      <= EXEC;
                        busy       <= 1'b1;
                    end
                end
                EXEC: begin
                    // Owner's buffer was empty at accept, so no drain can collide here.
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (owner) begin
                        rsp1_valid  <= 1'b1;
                        rsp1_result <= alu_result;
                        rsp1_flags  <= alu_flags;
                    end else begin
                        rsp0_valid  <= 1'b1;
                        rsp0_result <= alu_result;
                        rsp0_flags  <= alu_flags;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU attached to its ALU ports.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_flags, rsp1_flags;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic [3:0]  alu_flags;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    logic [35:0] q0[$];
    logic [35:0] q1[$];
    int grants[$];

    alu_share_arbiter #(.Width(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: flags {N,Z,C,V}; C on subtract means "no borrow".
    logic [32:0] alu_sum;
    logic        alu_c, alu_v;
    always_comb begin
        alu_sum    = 33'd0;
        alu_result = 32'd0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (alu_ctrl)
            3'b000: begin
                alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = alu_sum[31:0];
                alu_c      = alu_sum[32];
                alu_v      = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b001: begin
                alu_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result = alu_sum[31:0];
                alu_c      = alu_sum[32];
                alu_v      = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        alu_flags = {alu_result[31], (alu_result == 32'd0), alu_c, alu_v};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Monitor: response handshakes pop the scoreboard; also watches grant order and exclusivity.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_exclusive", {63'd0, req0_ready & req1_ready}, 64'd0);
            if (req0_valid && req0_ready) grants.push_back(0);
            if (req1_valid && req1_ready) grants.push_back(1);
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) fail_now("rsp0_unexpected");
                else check("rsp0_data", {28'd0, rsp0_result, rsp0_flags}, {28'd0, q0.pop_front()});
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) fail_now("rsp1_unexpected");
                else check("rsp1_data", {28'd0, rsp1_result, rsp1_flags}, {28'd0, q1.pop_front()});
            end
        end
    end

    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                         input logic [31:0] er, input logic [3:0] ef, input bit push);
        if (p == 0) begin req0_a = a; req0_b = b; req0_ctrl = c; req0_valid = 1'b1; end
        else        begin req1_a = a; req1_b = b; req1_ctrl = c; req1_valid = 1'b1; end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
                @(posedge clk); #1;
                if (p == 0) begin req0_valid = 1'b0; if (push) q0.push_back({er, ef}); end
                else        begin req1_valid = 1'b0; if (push) q1.push_back({er, ef}); end
                return;
            end
            @(posedge clk); #1;
        end
        fail_now(p == 0 ? "issue0" : "issue1");
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (q0.size() == 0 && q1.size() == 0 && !rsp0_valid && !rsp1_valid) return;
        end
        fail_now("drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = 3'b000;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = 3'b000;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
        check("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_alu_a", {32'd0, alu_a}, 64'd0);
        check("rst_alu_b", {32'd0, alu_b}, 64'd0);
        check("rst_alu_ctrl", {61'd0, alu_ctrl}, 64'd0);
        check("rst_rsp0_data", {28'd0, rsp0_result, rsp0_flags}, 64'd0);
        check("rst_rsp1_data", {28'd0, rsp1_result, rsp1_flags}, 64'd0);
        req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 3'b001; req0_valid = 1'b1;
        rst_n = 1'b1;
        #1;
        check("first_idle_ready0", {63'd0, req0_ready}, 64'd1);

        // Single subtract on port 0
        issue(0, 32'd5, 32'd3, 3'b001, 32'd2, 4'b0010, 1'b1);
        check("exec_busy", {63'd0, busy}, 64'd1);
        check("exec_alu_a", {32'd0, alu_a}, 64'd5);
        check("exec_alu_b", {32'd0, alu_b}, 64'd3);
        check("exec_alu_ctrl", {61'd0, alu_ctrl}, 64'd1);
        check("exec_ready0", {63'd0, req0_ready}, 64'd0);
        @(posedge clk); #1;
        check("lat_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
        check("lat_busy", {63'd0, busy}, 64'd0);
        wait_drain();

        // SLT on port 1 (also leaves last_grant at 1)
        issue(1, 32'hffffffff, 32'd1, 3'b101, 32'd1, 4'b0000, 1'b1);
        issue(1, 32'd1, 32'hffffffff, 3'b101, 32'd0, 4'b0100, 1'b1);
        wait_drain();
        check("idle_holds_alu_a", {32'd0, alu_a}, 64'd1);

        // Contention: expect grants 0,1,0,1
        grants.delete();
        fork
            begin
                issue(0, 32'd10, 32'd20, 3'b000, 32'd30, 4'b0000, 1'b1);
                issue(0, 32'hf0f0f0f0, 32'hff00ff00, 3'b010, 32'hf000f000, 4'b1000, 1'b1);
            end
            begin
                issue(1, 32'h7fffffff, 32'd1, 3'b000, 32'h80000000, 4'b1001, 1'b1);
                issue(1, 32'd0, 32'd0, 3'b011, 32'd0, 4'b0100, 1'b1);
            end
        join
        wait_drain();
        check("grant_count", {32'd0, grants.size()}, 64'd4);
        g = 0;
        foreach (grants[i]) g = (g << 1) | grants[i];
        check("grant_order", {32'd0, g}, 64'h5);

        // Backpressure on response 0
        rsp0_ready = 1'b0;
        issue(0, 32'd9, 32'd4, 3'b000, 32'd13, 4'b0000, 1'b1);
        @(posedge clk); #1;
        check("bp_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
        req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 3'b001; req0_valid = 1'b1;
        fork
            issue(1, 32'd3, 32'd6, 3'b010, 32'd2, 4'b0000, 1'b1);
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("bp_ready0_low", {63'd0, req0_ready}, 64'd0);
                    check("bp_rsp0_stable", {28'd0, rsp0_result, rsp0_flags}, {28'd0, 32'd13, 4'b0000});
                end
            end
        join
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        issue(0, 32'd1, 32'd1, 3'b001, 32'd0, 4'b0110, 1'b1);
        wait_drain();

        // Reset while executing discards the op
        issue(0, 32'd8, 32'd8, 3'b000, 32'd0, 4'b0000, 1'b0);
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_alu_a", {32'd0, alu_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mid_no_rsp", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
            check("mid_idle", {63'd0, busy}, 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
